// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } pc_state_e;

  localparam int unsigned PC_WIDTH_DEF  = 16;
  localparam int unsigned PC_STEP_DEF   = 2;
  localparam int unsigned RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. It keeps the newest RAS_DEPTH entries and
// overwrites the oldest entry when a push arrives while the stack is full.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0]  ptr_q, ptr_d, ptr_m1;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty_q, full_q;
  logic [WIDTH-1:0] mem_q [RAS_DEPTH];

  // ptr_q is the next write slot; the top entry sits one slot below it.
  assign ptr_m1 = ptr_q - PtrW'(1);
  assign top    = mem_q[ptr_m1];
  assign empty  = empty_q;
  assign full   = full_q;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + CntW'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_m1;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == CntW'(RAS_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: handles stall, halt and redirect, and uses a
// return-address stack for call/return.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = PC_WIDTH_DEF,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       STEP      = PC_STEP_DEF,
  parameter int unsigned       RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             call_valid,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_top;
  logic             push, pop;
  logic             uflow_q, uflow_d;

  assign pc            = pc_q;
  assign pc_plus       = pc_q + WIDTH'(STEP);
  assign halted        = (state_q == StHalted);
  assign ras_underflow = uflow_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    uflow_d = 1'b0;
    unique case (state_q)
      StRun: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = StHalted;
        end else if (ret_valid) begin
          // A return on an empty stack falls through sequentially.
          if (ras_empty) begin
            pc_d    = pc_plus;
            uflow_d = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end else if (call_valid) begin
          push = 1'b1;
          pc_d = call_target;
        end else begin
          pc_d = pc_plus;
        end
      end
      StHalted: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_VEC;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      uflow_q <= uflow_d;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule
